// File: rtl/deflate_bit_packer.sv
// deflate_bit_packer
//   Packs variable-length LSB-first bit chunks (0..32 bits per cycle) into a
//   contiguous bitstream and emits 32-bit little-endian words with a
//   valid/ready handshake. On the last chunk of a stream, the final partial
//   word is zero-padded to a byte boundary and flagged with out_last. A stream
//   that ends exactly on a word boundary, or is empty, closes with an empty
//   terminal word (bytes=0, last=1).
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input chunk handshake
//   in_size, in_data      chunk length (0..32, larger clamps) and bits
//   in_last               chunk closes the stream
//   out_valid/out_ready   output word handshake
//   out_data, out_bytes   packed word and number of valid bytes (0..4)
//   out_last              terminal word of the stream
//   err                   sticky: [0] chunk dropped (in_ready=0), [1] in_size>32
module deflate_bit_packer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SIZE_WIDTH = 6,
  parameter int unsigned BUF_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [SIZE_WIDTH-1:0] in_size,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [2:0]            out_bytes,
  output logic                  out_last,
  output logic [1:0]            err
);

  localparam int unsigned FillW = $clog2(BUF_WIDTH) + 1;
  localparam logic [FillW-1:0] WordBits = FillW'(DATA_WIDTH);

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e                  state_q, state_d;
  logic [BUF_WIDTH-1:0]    buf_q, buf_d;
  logic [FillW-1:0]        fill_q, fill_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [2:0]              out_bytes_q, out_bytes_d;
  logic                    out_last_q, out_last_d;
  logic [1:0]              err_q, err_d;

  logic                    ready_run;
  logic                    accept;
  logic                    slot_free;
  logic                    pop;
  logic                    term;
  logic                    term_done;
  logic                    size_big;
  logic [SIZE_WIDTH-1:0]   size_eff;
  logic [DATA_WIDTH-1:0]   mask;
  logic [BUF_WIDTH-1:0]    chunk_ext;
  logic [BUF_WIDTH-1:0]    buf_shift;
  logic [FillW-1:0]        pos;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (accept && in_last) state_d = StFlush;
      StFlush: if (term_done)         state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  // FSM: outputs
  always_comb begin
    ready_run = (state_q == StRun) && (fill_q <= WordBits);
    // Held low while reset is asserted so no chunk looks accepted.
    in_ready  = rst_n && ready_run;
  end

  // ---------------------------------------------------------------------------
  // Datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    size_big  = in_size > SIZE_WIDTH'(DATA_WIDTH);
    size_eff  = size_big ? SIZE_WIDTH'(DATA_WIDTH) : in_size;
    mask      = (size_eff == SIZE_WIDTH'(DATA_WIDTH)) ? '1
                : ((DATA_WIDTH'(1) << size_eff) - DATA_WIDTH'(1));
    chunk_ext = BUF_WIDTH'(in_data & mask);

    accept    = in_valid && ready_run;
    slot_free = !out_valid_q || out_ready;
    pop       = slot_free && (fill_q >= WordBits);
    // The terminal word is issued once; while it waits in the slot
    // (out_valid & out_last) no second one may be generated.
    term      = (state_q == StFlush) && slot_free && (fill_q < WordBits) &&
                !(out_valid_q && out_last_q);
    term_done = (state_q == StFlush) && out_valid_q && out_last_q && out_ready;

    buf_shift = pop ? (buf_q >> DATA_WIDTH) : buf_q;
    pos       = pop ? (fill_q - WordBits) : fill_q;
  end

  // Next-state for accumulator, output slot and error flags
  always_comb begin
    buf_d       = buf_shift;
    fill_d      = fill_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_bytes_d = out_bytes_q;
    out_last_d  = out_last_q;
    err_d       = err_q | {in_valid && size_big, in_valid && !ready_run};

    if (pop) begin
      fill_d = fill_q - WordBits;
    end
    if (accept) begin
      buf_d  = buf_shift | (chunk_ext << pos);
      fill_d = fill_d + FillW'(size_eff);
    end

    if (pop) begin
      out_valid_d = 1'b1;
      out_data_d  = buf_q[DATA_WIDTH-1:0];
      out_bytes_d = 3'd4;
      out_last_d  = 1'b0;
    end else if (term) begin
      // Bits above fill are always zero, so the low word is already padded.
      out_valid_d = 1'b1;
      out_data_d  = buf_q[DATA_WIDTH-1:0];
      out_bytes_d = 3'((fill_q + FillW'(7)) >> 3);
      out_last_d  = 1'b1;
      buf_d       = '0;
      fill_d      = '0;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q       <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_bytes_q <= '0;
      out_last_q  <= 1'b0;
      err_q       <= '0;
    end else begin
      buf_q       <= buf_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_bytes_q <= out_bytes_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_bytes = out_bytes_q;
  assign out_last  = out_last_q;
  assign err       = err_q;

endmodule

// File: tb/tb_deflate_bit_packer.sv
module tb_deflate_bit_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [5:0]  in_size = '0;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [2:0]  out_bytes;
  logic        out_last;
  logic [1:0]  err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] q_data[$];
  logic [2:0]  q_bytes[$];
  logic        q_last[$];
  int          q_cyc[$];

  deflate_bit_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_size   (in_size),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_bytes (out_bytes),
    .out_last  (out_last),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Words are recorded half a cycle before the edge that transfers them.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_bytes.push_back(out_bytes);
      q_last.push_back(out_last);
      q_cyc.push_back(cyc);
    end
  end

  typedef struct {
    int          size;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic [2:0]  exp_bytes;
  } vec_t;

  vec_t tbl[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic clear_q();
    q_data.delete();
    q_bytes.delete();
    q_last.delete();
    q_cyc.delete();
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 100; i++) begin
      if (in_ready) break;
      step();
    end
    if (!in_ready) check({name, "_ready_timeout"}, 64'(in_ready), 64'd1);
  endtask

  task automatic send(input string name, input int sz, input logic [31:0] d, input bit last);
    wait_ready(name);
    in_valid = 1'b1;
    in_size  = 6'(sz);
    in_data  = d;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_size  = '0;
    in_data  = '0;
    in_last  = 1'b0;
  endtask

  task automatic wait_last(input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (q_last.size() > 0) found = q_last[q_last.size()-1];
    end
    check({name, "_last_seen"}, 64'(found), 64'd1);
  endtask

  task automatic expect_word(input string name, input int idx, input logic [31:0] d,
                             input logic [2:0] b, input logic l);
    if (idx >= q_data.size()) begin
      check({name, "_present"}, 64'(q_data.size()), 64'(idx + 1));
    end else begin
      check({name, "_data"}, 64'(q_data[idx]), 64'(d));
      check({name, "_bytes"}, 64'(q_bytes[idx]), 64'(b));
      check({name, "_last"}, 64'(q_last[idx]), 64'(l));
    end
  endtask

  initial begin
    int stable_bad;
    logic [31:0] snap;

    tbl[0] = '{1,  32'hFFFF_FFFF, 32'h0000_0001, 3'd1};
    tbl[1] = '{8,  32'h0000_0123, 32'h0000_0023, 3'd1};
    tbl[2] = '{9,  32'h0000_FFFF, 32'h0000_01FF, 3'd2};
    tbl[3] = '{17, 32'hFFFF_FFFF, 32'h0001_FFFF, 3'd3};
    tbl[4] = '{24, 32'hABCD_EF12, 32'h00CD_EF12, 3'd3};
    tbl[5] = '{25, 32'hFFFF_FFFF, 32'h01FF_FFFF, 3'd4};
    tbl[6] = '{31, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 3'd4};
    tbl[7] = '{0,  32'hFFFF_FFFF, 32'h0000_0000, 3'd0};

    // Reset state
    #2;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_err", 64'(err), 64'd0);

    // Reset mid-stream with fill=20 and a word held in the output slot
    out_ready = 1'b0;
    send("mid", 32, 32'h1111_1111, 1'b0);
    send("mid", 20, 32'h000F_FFFF, 1'b0);
    check("mid_out_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_outs", {27'd0, out_valid, out_data, out_bytes, out_last},
          64'd0);
    check("mid_rst_ready_err", {in_ready, err}, 64'd0);
    #2;
    rst_n = 1'b1;
    step();
    clear_q();
    out_ready = 1'b1;
    check("mid_release_ready", 64'(in_ready), 64'd1);
    send("mid_new", 8, 32'h0000_00AB, 1'b1);
    wait_last("mid_new");
    check("mid_new_nwords", 64'(q_data.size()), 64'd1);
    expect_word("mid_new_w0", 0, 32'h0000_00AB, 3'd1, 1'b1);

    // Eight nibbles then a final nibble
    clear_q();
    for (int i = 1; i <= 8; i++) send("nib", 4, 32'(i), 1'b0);
    send("nib", 4, 32'h9, 1'b1);
    wait_last("nib");
    check("nib_nwords", 64'(q_data.size()), 64'd2);
    expect_word("nib_w0", 0, 32'h8765_4321, 3'd4, 1'b0);
    expect_word("nib_w1", 1, 32'h0000_0009, 3'd1, 1'b1);

    // Back-to-back full words
    clear_q();
    send("b2b", 32, 32'hA5A5_A5A5, 1'b0);
    check("b2b_ready_held", 64'(in_ready), 64'd1);
    send("b2b", 32, 32'h1234_5678, 1'b1);
    wait_last("b2b");
    check("b2b_nwords", 64'(q_data.size()), 64'd3);
    expect_word("b2b_w0", 0, 32'hA5A5_A5A5, 3'd4, 1'b0);
    expect_word("b2b_w1", 1, 32'h1234_5678, 3'd4, 1'b0);
    expect_word("b2b_w2", 2, 32'h0000_0000, 3'd0, 1'b1);
    if (q_cyc.size() >= 2) check("b2b_rate", 64'(q_cyc[1] - q_cyc[0]), 64'd1);

    // 7 + 9 + 13 bits, junk above each size must be masked
    clear_q();
    send("odd", 7,  32'hFFFF_FFD5, 1'b0);
    send("odd", 9,  32'hFFFF_FFA3, 1'b0);
    send("odd", 13, 32'hFFFF_1234, 1'b1);
    wait_last("odd");
    check("odd_nwords", 64'(q_data.size()), 64'd1);
    expect_word("odd_w0", 0, 32'h1234_D1D5, 3'd4, 1'b1);

    // Backpressure: fill reaches 64, dropped chunk, then drain
    clear_q();
    check("stall_err_before", 64'(err), 64'd0);
    out_ready = 1'b0;
    send("stall", 32, 32'h1111_2222, 1'b0);
    send("stall", 32, 32'h3333_4444, 1'b0);
    send("stall", 32, 32'h5555_6666, 1'b0);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    check("stall_out_data", 64'(out_data), 64'h1111_2222);
    snap = out_data;
    stable_bad = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 1);
      in_size  = 6'd32;
      in_data  = 32'hDEAD_BEEF;
      step();
      in_valid = 1'b0;
      if (out_data !== snap || out_valid !== 1'b1 || out_bytes !== 3'd4 || in_ready !== 1'b0)
        stable_bad++;
    end
    check("stall_stable", 64'(stable_bad), 64'd0);
    check("stall_err0", 64'(err), 64'b01);
    out_ready = 1'b1;
    send("stall", 8, 32'h0000_0077, 1'b1);
    wait_last("stall");
    check("stall_nwords", 64'(q_data.size()), 64'd4);
    expect_word("stall_w0", 0, 32'h1111_2222, 3'd4, 1'b0);
    expect_word("stall_w1", 1, 32'h3333_4444, 3'd4, 1'b0);
    expect_word("stall_w2", 2, 32'h5555_6666, 3'd4, 1'b0);
    expect_word("stall_w3", 3, 32'h0000_0077, 3'd1, 1'b1);

    // Oversize chunk clamps to 32 bits
    clear_q();
    send("big", 40, 32'hFFFF_FFFF, 1'b1);
    wait_last("big");
    check("big_err", 64'(err), 64'b11);
    check("big_nwords", 64'(q_data.size()), 64'd2);
    expect_word("big_w0", 0, 32'hFFFF_FFFF, 3'd4, 1'b0);
    expect_word("big_w1", 1, 32'h0000_0000, 3'd0, 1'b1);

    // Single-chunk streams: masking and byte rounding (size 0 = empty stream)
    for (int k = 0; k < 8; k++) begin
      clear_q();
      send($sformatf("tbl%0d", k), tbl[k].size, tbl[k].data, 1'b1);
      wait_last($sformatf("tbl%0d", k));
      check($sformatf("tbl%0d_nwords", k), 64'(q_data.size()), 64'd1);
      expect_word($sformatf("tbl%0d_w0", k), 0, tbl[k].exp_data, tbl[k].exp_bytes, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/deflate_bit_packer.md
Name: deflate_bit_packer

Overview:
- Consumes the variable-length, LSB-first bit chunks produced by the LZ77 match-filter stage (valid/size/data, up to 32 bits per cycle).
- Packs them into a contiguous bitstream and emits 32-bit little-endian words to the Xillybus output FIFO, with a valid/ready handshake.
- At end of stream it zero-pads the final partial word to a byte boundary and marks it last, so the downstream CRC32/ISIZE trailer logic can append directly.

Parameters:
- DATA_WIDTH, 32, input chunk and output word width; only 32 is supported.
- SIZE_WIDTH, 6, width of in_size; encodes 0..32.
- BUF_WIDTH, 64, internal accumulator width; must equal 2*DATA_WIDTH.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; asynchronous, active-low
- in_valid  input  1  chunk present
- in_size  input  6  number of valid bits in in_data, 0..32
- in_data  input  32  chunk bits; bit 0 is the first bit in the stream; bits at or above in_size are ignored (masked)
- in_last  input  1  chunk is the final one of the stream
- in_ready  output  1  packer accepts a chunk this cycle
- out_valid  output  1  out_data holds a word
- out_ready  input  1  downstream accepts the word
- out_data  output  32  packed bits, stream bit 0 in bit 0
- out_bytes  output  3  valid bytes in out_data, 0..4
- out_last  output  1  final word of the stream
- err  output  2  sticky flags: [0] chunk offered while in_ready=0; [1] in_size>32

Behaviour:
- Reset: buf=0, fill=0, state=RUN; out_valid=0, out_data=0, out_bytes=0, out_last=0, err=0, in_ready=0. Assertion mid-stream discards all buffered bits immediately.
- State RUN:
  - in_ready = (fill<=32).
  - Accept happens on an edge with in_valid & in_ready. The masked chunk is written at bit position fill (or fill-32 if a pop happens at the same edge).
  - fill' = fill + in_size - (pop?32:0).
- Pop:
  - Occurs at an edge where the output slot is free (!out_valid | out_ready) and fill>=32, in RUN or FLUSH.
  - The low 32 bits of buf load out_data, with out_bytes=4 and out_last=0. buf shifts right 32.
  - Simultaneous accept and pop is allowed. Sustained throughput is one 32-bit chunk per cycle.
- Latency:
  - A chunk accepted at edge n whose bits complete a word appears with out_valid=1 after edge n+1, if the slot is free.
  - out_* hold stable while out_valid & !out_ready.
- in_last accepted: state→FLUSH. In FLUSH, in_ready=0.
- FLUSH:
  - Pop full words while fill>=32.
  - When 0<fill<32 and the slot is free, emit the terminal word:
    - out_data = buf bits [fill-1:0], zero above;
    - out_bytes = ceil(fill/8);
    - out_last = 1;
    - fill→0.
  - When fill==0 (stream ended on a 32-bit boundary, or the stream was empty), emit an empty terminal word: out_data=0, out_bytes=0, out_last=1.
  - Once the terminal word is accepted (out_valid & out_ready), state→RUN and the packer is ready for a new stream on the next cycle.
- in_size=0 with in_valid: accepted, fill unchanged. With in_last it still triggers FLUSH.
- in_size>32: treated as 32 and err[1] set.
- in_valid while in_ready=0: chunk dropped, err[0] set. Upstream has no backpressure, so err[0] is the system-level overflow indicator.
- err clears only on reset.
- out_valid falls after an edge with out_ready=1 and no new pop.

Test Plan:
- Reset mid-stream (fill=20, out_valid=1) → all outputs 0 on the reset edge; after release, in_ready=1, fill=0.
- Eight chunks of size 4 carrying 0x1..0x8, then a 4-bit chunk with in_last → words 0x87654321 (bytes=4, last=0) and then 0x00000009 (bytes=1, last=1).
- Back-to-back 32-bit chunks 0xA5A5A5A5, 0x12345678 with out_ready=1 → in_ready stays 1; one word per cycle, outputs equal the inputs in order; the last chunk flagged in_last gives a trailing empty word (bytes=0, last=1).
- Chunks 7+9+13 bits, last on the 13-bit chunk → one terminal word: 29 bits concatenated LSB-first, zero-padded, bytes=4, last=1.
- out_ready held 0 for 5 cycles with fill reaching 64 → in_ready=0 and out_* stable. A chunk offered meanwhile is dropped and sets err[0]. On release, words drain in order.
- in_size=40 with data 0xFFFFFFFF → err[1]=1 and 32 bits are packed; an empty stream (single size-0 chunk with in_last) → one word with bytes=0, last=1.
